// File: rtl/apb_nslave_pkg.sv
// apb_nslave_pkg: shared types and helpers for the parametrised APB master bridge.
//   state_e   - requester FSM states (IDLE, SETUP, ACCESS)
//   apb_cmd_t - one command as seen on the command side (address, write data, read flag),
//               sized for the widest supported configuration (32-bit address and data)
//   sel_w()   - number of upper address bits used to pick a completer
package apb_nslave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        read;
    } apb_cmd_t;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// apb_slave_decoder: combinational completer select from the upper address bits.
//   addr_i    - latched command address; the top sel_w(NUM_SLAVES) bits form the slave index
//   psel_o    - one-hot completer mask, all zero when the index names no completer
//   dec_err_o - index >= NUM_SLAVES (only possible when NUM_SLAVES is not a power of two)
module apb_slave_decoder
    import apb_nslave_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 9
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [NUM_SLAVES-1:0] psel_o,
    output logic                  dec_err_o
);

    localparam int SEL_W = sel_w(NUM_SLAVES);

    logic [SEL_W-1:0] idx;
    logic             unused_low;

    assign idx        = addr_i[ADDR_W-1 -: SEL_W];
    // the offset bits inside a completer's window take no part in the decode
    assign unused_low = ^addr_i[ADDR_W-SEL_W-1:0];
    assign dec_err_o  = int'(idx) >= NUM_SLAVES;

    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) psel_o[i] = int'(idx) == i;
    end

endmodule

// File: rtl/apb_nslave_master.sv
// apb_nslave_master: APB requester bridging single read/write commands to NUM_SLAVES completers.
//   PCLK, PRESET                   - clock (rising edge), asynchronous active-high reset
//   transfer, READ_WRITE           - command valid, 1 = read / 0 = write
//   apb_write_paddr/apb_write_data - write command address and data
//   apb_read_paddr                 - read command address
//   cmd_ready                      - command taken on an edge where transfer & cmd_ready
//   done, PSLVERR                  - one-cycle completion pulse and its error flag
//   apb_read_data_out              - read data, updated on read completions only
//   PADDR/PWRITE/PWDATA/PENABLE/PSEL - APB requester outputs
//   PRDATA/PREADY/PSLVERR_S        - per-completer responses, completer i at slice i
// Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_nslave_master
    import apb_nslave_pkg::*;
#(
    parameter int NUM_SLAVES     = 2,
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         READ_WRITE,
    input  logic [ADDR_W-1:0]            apb_write_paddr,
    input  logic [DATA_W-1:0]            apb_write_data,
    input  logic [ADDR_W-1:0]            apb_read_paddr,
    output logic                         cmd_ready,
    output logic                         done,
    output logic                         PSLVERR,
    output logic [DATA_W-1:0]            apb_read_data_out,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S
);

    if (NUM_SLAVES < 2 || NUM_SLAVES > 16 || ADDR_W <= sel_w(NUM_SLAVES) || TIMEOUT_CYCLES < 1)
    begin : g_param_err
        $error("apb_nslave_master: unsupported parameter set");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                write_q, write_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                live_q;
    logic [NUM_SLAVES-1:0] dec_psel;
    logic                dec_err;
    logic                rdy, serr, accept, complete, abort;
    logic [DATA_W-1:0]   prd;

    apb_slave_decoder #(
        .NUM_SLAVES(NUM_SLAVES),
        .ADDR_W    (ADDR_W)
    ) u_dec (
        .addr_i   (addr_q),
        .psel_o   (dec_psel),
        .dec_err_o(dec_err)
    );

    // Responses of unselected completers are masked out; a decode error has an
    // empty mask, so it reads as zero data and completes immediately.
    always_comb begin
        prd = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            prd = prd | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{dec_psel[i]}});
    end

    assign rdy      = dec_err | |(PREADY & dec_psel);
    assign serr     = |(PSLVERR_S & dec_psel);
    assign complete = (state_q == ACCESS) & rdy;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign abort = (state_q == ACCESS) & ~rdy & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign cnt_d = (state_q == SETUP) ? '0 :
                   ((state_q == ACCESS) & ~rdy & ~abort) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign abort = 1'b0;
`endif

    // live_q keeps cmd_ready low during reset and until the first edge after release.
    assign cmd_ready = live_q & ((state_q == IDLE) | complete);
    assign accept    = transfer & cmd_ready;

    assign state_d = accept              ? SETUP  :
                     (state_q == SETUP)  ? ACCESS :
                     (complete | abort)  ? IDLE   : state_q;
    assign addr_d  = accept ? (READ_WRITE ? apb_read_paddr : apb_write_paddr) : addr_q;
    assign write_d = accept ? ~READ_WRITE : write_q;
    assign wdata_d = accept ? (READ_WRITE ? '0 : apb_write_data) : wdata_q;
    assign done_d  = complete | abort;
    assign err_d   = abort | (complete & (dec_err | serr));
    assign rdata_d = (complete & ~write_q) ? prd :
                     (abort & ~write_q)    ? '0  : rdata_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    assign done              = done_q;
    assign PSLVERR           = err_q;
    assign apb_read_data_out = rdata_q;
    assign PADDR             = addr_q;
    assign PWRITE            = write_q;
    assign PWDATA            = wdata_q;
    assign PENABLE           = state_q == ACCESS;
    assign PSEL              = (state_q == SETUP || state_q == ACCESS) ? dec_psel : '0;

endmodule

// File: tb/tb_apb_nslave_master.sv
// tb_apb_nslave_master: self-checking bench for apb_nslave_master (3 completers, 9-bit address, 8-bit data).
module tb_apb_nslave_master;
    import apb_nslave_pkg::*;

    localparam int NS = 3;
    localparam int AW = 9;
    localparam int DW = 8;

    logic            PCLK = 1'b0, PRESET = 1'b0, transfer = 1'b0, READ_WRITE = 1'b0;
    logic [AW-1:0]   apb_write_paddr = '0, apb_read_paddr = '0;
    logic [DW-1:0]   apb_write_data = '0;
    logic            cmd_ready, done, PSLVERR, PWRITE, PENABLE;
    logic [DW-1:0]   apb_read_data_out, PWDATA;
    logic [AW-1:0]   PADDR;
    logic [NS-1:0]   PSEL, PREADY;
    logic [NS-1:0]   PSLVERR_S = '0;
    logic [NS*DW-1:0] PRDATA;
    logic [DW-1:0]   srd [NS] = '{8'h0, 8'h0, 8'h0};
    int              wait_n [NS] = '{0, 0, 0};
    int              cnt [NS] = '{0, 0, 0};
    int              total = 0, bad = 0;
    logic [DW-1:0]   model_rdo = '0;

    typedef struct {
        apb_cmd_t      cmd;
        int            waits;
        logic [DW-1:0] srdata;
        logic          serr;
        logic [NS-1:0] e_psel;
        int            e_lat;
        logic          e_err;
        logic [DW-1:0] e_rdo;
    } vec_t;

    apb_nslave_master #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .cmd_ready(cmd_ready), .done(done),
        .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR_S(PSLVERR_S)
    );

    always #5 PCLK = ~PCLK;

    // Completer model: ready after wait_n[j] ACCESS cycles; idle completers drive
    // PREADY high so a master that ignored PSEL would finish too early.
    always @(posedge PCLK)
        for (int j = 0; j < NS; j++) cnt[j] <= (PSEL[j] && PENABLE) ? cnt[j] + 1 : 0;

    always_comb
        for (int j = 0; j < NS; j++)
            PREADY[j] = (PSEL[j] && PENABLE) ? (cnt[j] >= wait_n[j]) : 1'b1;

    always_comb
        for (int j = 0; j < NS; j++) PRDATA[j*DW +: DW] = srd[j];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input int addr, input int wdata, input int waits,
                                input int srdata, input logic serr, input int e_psel,
                                input int e_lat, input logic e_err, input int e_rdo);
        vec_t v;
        v.cmd.read  = rd;
        v.cmd.addr  = 32'(addr);
        v.cmd.wdata = 32'(wdata);
        v.waits     = waits;
        v.srdata    = DW'(srdata);
        v.serr      = serr;
        v.e_psel    = NS'(e_psel);
        v.e_lat     = e_lat;
        v.e_err     = e_err;
        v.e_rdo     = DW'(e_rdo);
        return v;
    endfunction

    // One isolated transfer from IDLE; k counts negedges after the accepting edge.
    task automatic run(input vec_t v, input string tag);
        logic [AW-1:0] a;
        int            idx, k;
        bit            ok;
        a   = v.cmd.addr[AW-1:0];
        idx = int'(a) >> 7;
        @(posedge PCLK); #1;
        for (int j = 0; j < NS; j++) begin
            srd[j] = DW'($urandom);
            PSLVERR_S[j] = 1'($urandom);
            wait_n[j] = 0;
        end
        if (idx < NS) begin
            srd[idx] = v.srdata;
            PSLVERR_S[idx] = v.serr;
            wait_n[idx] = v.waits;
        end
        transfer        = 1'b1;
        READ_WRITE      = v.cmd.read;
        apb_read_paddr  = v.cmd.read ? a : AW'($urandom);
        apb_write_paddr = v.cmd.read ? AW'($urandom) : a;
        apb_write_data  = v.cmd.wdata[DW-1:0];
        @(negedge PCLK);
        chk({tag, "_ready"}, 32'(cmd_ready), 1);
        @(posedge PCLK); #1;
        transfer        = 1'b0;
        READ_WRITE      = 1'($urandom);
        apb_read_paddr  = AW'($urandom);
        apb_write_paddr = AW'($urandom);
        apb_write_data  = DW'($urandom);
        @(negedge PCLK);
        chk({tag, "_setup"}, 32'({PSEL, PENABLE, PWRITE, PWDATA, PADDR}),
            32'({v.e_psel, 1'b0, ~v.cmd.read, v.cmd.read ? DW'(0) : v.cmd.wdata[DW-1:0], a}));
        ok = 1'b1;
        for (k = 2; k < 60; k++) begin
            @(negedge PCLK);
            if (done) break;
            if ({PSEL, PENABLE, PADDR, PWRITE} !== {v.e_psel, 1'b1, a, ~v.cmd.read}) ok = 1'b0;
        end
        chk({tag, "_hold"}, 32'(ok), 1);
        chk({tag, "_lat"}, 32'(k), 32'(v.e_lat));
        chk({tag, "_resp"}, 32'({done, PSLVERR, PSEL, PENABLE, apb_read_data_out}),
            32'({1'b1, v.e_err, NS'(0), 1'b0, v.e_rdo}));
        @(negedge PCLK);
        chk({tag, "_pulse"}, 32'(done), 0);
        model_rdo = v.e_rdo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        vec_t v;
        int   idx, nd;

        tbl[0] = mk(0, 'h0A5, 'h3C, 0, 'h00, 0, 'b010, 3, 0, 'h00);
        tbl[1] = mk(1, 'h012, 'hEE, 3, 'h5A, 0, 'b001, 6, 0, 'h5A);
        tbl[2] = mk(0, 'h0C3, 'h77, 1, 'h11, 1, 'b010, 4, 1, 'h5A);
        tbl[3] = mk(1, 'h1C0, 'h00, 0, 'h00, 0, 'b000, 3, 1, 'h00);
        tbl[4] = mk(1, 'h155, 'h42, 2, 'hA7, 1, 'b100, 5, 1, 'hA7);
        tbl[5] = mk(0, 'h1FF, 'h99, 0, 'h00, 0, 'b000, 3, 1, 'hA7);
        tbl[6] = mk(1, 'h17F, 'h00, 0, 'h81, 0, 'b100, 3, 0, 'h81);

        #1 PRESET = 1'b1;
        #3;
        chk("reset_outputs", 32'({cmd_ready, done, PSLVERR, PWRITE, PENABLE, PSEL}), 0);
        chk("reset_busses", 32'({PWDATA, apb_read_data_out, PADDR}), 0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("reset_release_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // back-to-back: write slave 0, then read slave 1 with transfer held high
        @(posedge PCLK); #1;
        srd[1] = 8'h6B;
        PSLVERR_S = '0;
        for (int j = 0; j < NS; j++) wait_n[j] = 0;
        transfer = 1'b1;
        READ_WRITE = 1'b0;
        apb_write_paddr = 9'h011;
        apb_write_data = 8'h99;
        @(negedge PCLK);
        chk("b2b_readyA", 32'(cmd_ready), 1);
        @(posedge PCLK); #1;
        READ_WRITE = 1'b1;
        apb_read_paddr = 9'h0AA;
        @(negedge PCLK);
        chk("b2b_setupA", 32'({PSEL, PENABLE, cmd_ready}), 32'({3'b001, 1'b0, 1'b0}));
        @(negedge PCLK);
        chk("b2b_accessA", 32'({PSEL, PENABLE, PWDATA, cmd_ready}), 32'({3'b001, 1'b1, 8'h99, 1'b1}));
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(negedge PCLK);
        chk("b2b_doneA_setupB", 32'({done, PSLVERR, PSEL, PENABLE, PWRITE, PADDR, apb_read_data_out}),
            32'({1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 9'h0AA, 8'h81}));
        @(negedge PCLK);
        chk("b2b_accessB", 32'({done, PSEL, PENABLE}), 32'({1'b0, 3'b010, 1'b1}));
        @(negedge PCLK);
        chk("b2b_doneB", 32'({done, PSLVERR, PSEL, apb_read_data_out}), 32'({1'b1, 1'b0, 3'b000, 8'h6B}));
        model_rdo = 8'h6B;

        // randomized transfers against a rule-level model
        for (int n = 0; n < 40; n++) begin
            v.cmd.read  = 1'($urandom);
            v.cmd.addr  = 32'($urandom_range(0, 511));
            v.cmd.wdata = 32'($urandom_range(0, 255));
            v.waits     = $urandom_range(0, 3);
            v.srdata    = DW'($urandom);
            v.serr      = 1'($urandom);
            idx = int'(v.cmd.addr) >> 7;
            if (idx >= NS) begin
                v.e_psel = '0;
                v.e_lat  = 3;
                v.e_err  = 1'b1;
                v.e_rdo  = v.cmd.read ? DW'(0) : model_rdo;
            end else begin
                v.e_psel = NS'(1 << idx);
                v.e_lat  = 3 + v.waits;
                v.e_err  = v.serr;
                v.e_rdo  = v.cmd.read ? v.srdata : model_rdo;
            end
            run(v, "rnd");
        end

`ifdef APB_TIMEOUT_EN
        run(mk(1, 'h100, 'h00, 1000, 'h5C, 0, 'b100, 7, 1, 'h00), "timeout");
`endif

        // reset in the middle of a stalled ACCESS
        @(posedge PCLK); #1;
        srd[2] = 8'hE1;
        wait_n[2] = 50;
        PSLVERR_S = '0;
        transfer = 1'b1;
        READ_WRITE = 1'b1;
        apb_read_paddr = 9'h120;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_pre_access", 32'({PENABLE, PSEL, PADDR}), 32'({1'b1, 3'b100, 9'h120}));
        #2 PRESET = 1'b1;
        #1;
        chk("rst_async_ctrl", 32'({cmd_ready, done, PSLVERR, PWRITE, PENABLE, PSEL}), 0);
        chk("rst_async_bus", 32'({PWDATA, apb_read_data_out, PADDR}), 0);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_mid_release_ready", 32'(cmd_ready), 1);
        nd = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (done) nd++;
        end
        chk("rst_no_done", 32'(nd), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
